// File: rtl/control_multiciclo.sv
// control_multiciclo: multicycle RISC-V (RV32I subset) control FSM.
//   clk, rst_n          clock and asynchronous active-low reset
//   op/funct3/funct7b5  instruction fields from the instruction register
//   zero, mem_ready     ALU zero flag and memory handshake
//   pc_write, ir_write, reg_write, mem_write   write strobes
//   adr_src, alu_src_a, alu_src_b, alu_control, result_src, imm_src   datapath selects
//   illegal, state      error flag and current state code
module control_multiciclo #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        ERROR    = 4'd15
    } state_t;

    state_t     state_q, state_d;
    logic       pc_w, ir_w, rw, mw;
    logic [2:0] exec_alu;
    logic       alu_f3_ok, br_f3_ok;

    assign alu_f3_ok = funct3 == 3'b000 || funct3 == 3'b010 || funct3 == 3'b110 || funct3 == 3'b111;
    assign br_f3_ok  = funct3[2:1] == 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = ERROR;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE:
                case (op)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011: state_d = alu_f3_ok ? EXECR : ERROR;
                    7'b0010011: state_d = alu_f3_ok ? EXECI : ERROR;
                    7'b1100011: state_d = br_f3_ok ? BRANCH : ERROR;
                    7'b1101111: state_d = JAL;
                    7'b0110111: state_d = LUI;
                    default:    state_d = ERROR;
                endcase
            MEMADR:   state_d = op == 7'b0000011 ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JAL:      state_d = ALUWB;
            LUI:      state_d = ALUWB;
            ERROR:    state_d = ILLEGAL_HALT ? ERROR : FETCH;
            default:  state_d = ERROR;
        endcase
    end

    // sub is only meaningful for R-type; addi with bit 30 set is still add
    assign exec_alu = funct3 == 3'b010 ? 3'b101 :
                      funct3 == 3'b110 ? 3'b011 :
                      funct3 == 3'b111 ? 3'b010 :
                      (state_q == EXECR && funct7b5) ? 3'b001 : 3'b000;

    assign imm_src = op == 7'b0100011 ? 3'b001 :
                     op == 7'b1100011 ? 3'b010 :
                     op == 7'b0110111 ? 3'b011 :
                     op == 7'b1101111 ? 3'b100 : 3'b000;

    always_comb begin
        pc_w        = 1'b0;
        ir_w        = 1'b0;
        rw          = 1'b0;
        mw          = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        result_src  = 2'b00;
        illegal     = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_w       = mem_ready;
                ir_w       = mem_ready;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                rw         = 1'b1;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mw      = 1'b1;
            end
            EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = exec_alu;
            end
            EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = exec_alu;
            end
            ALUWB:    rw = 1'b1;
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = 3'b001;
                pc_w        = zero ^ funct3[0];
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_w      = 1'b1;
            end
            LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            ERROR:    illegal = 1'b1;
            default:  ;
        endcase
    end

    // FETCH strobes follow mem_ready, so gate with rst_n to keep all strobes low during reset
    assign pc_write  = pc_w & rst_n;
    assign ir_write  = ir_w & rst_n;
    assign reg_write = rw & rst_n;
    assign mem_write = mw & rst_n;
    assign state     = state_q;
endmodule

// File: tb/tb_control_multiciclo.sv
// tb_control_multiciclo: table-driven scoreboard bench for control_multiciclo.
module tb_control_multiciclo;
    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, mr;
        logic [3:0] st, strb;
        logic [2:0] alu, imm;
        logic [1:0] a, b, rs;
        logic       adr, ill;
    } vec_t;

    localparam int LW = 7'h03, SW = 7'h23, RT = 7'h33, IT = 7'h13, BR = 7'h63, JL = 7'h6F, LU = 7'h37, BAD = 7'h7F;

    logic clk = 1'b0, rst_n = 1'b0, rst0_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic pc_write, ir_write, reg_write, mem_write, adr_src, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control, imm_src;
    logic [3:0] state;
    logic pc_write0, ir_write0, reg_write0, mem_write0, adr_src0, illegal0;
    logic [1:0] alu_src_a0, alu_src_b0, result_src0;
    logic [2:0] alu_control0, imm_src0;
    logic [3:0] state0;
    logic [21:0] act;

    int checks = 0, errors = 0, nvec = 0;
    vec_t vecs[$];
    vec_t sb[$];

    control_multiciclo dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_write(mem_write), .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .result_src(result_src), .imm_src(imm_src), .illegal(illegal),
        .state(state)
    );

    control_multiciclo #(.ILLEGAL_HALT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write0), .ir_write(ir_write0), .reg_write(reg_write0),
        .mem_write(mem_write0), .adr_src(adr_src0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
        .alu_control(alu_control0), .result_src(result_src0), .imm_src(imm_src0), .illegal(illegal0),
        .state(state0)
    );

    always #5 clk = ~clk;

    assign act = {state, pc_write, ir_write, reg_write, mem_write, alu_control, imm_src,
                  alu_src_a, alu_src_b, result_src, adr_src, illegal};

    function automatic vec_t mk(int o, int f3, int f7, int z, int mr, int st, int strb,
                                int alu, int imm, int a, int b, int rs, int adr, int ill);
        vec_t r;
        r.op = 7'(o); r.f3 = 3'(f3); r.f7 = 1'(f7); r.z = 1'(z); r.mr = 1'(mr);
        r.st = 4'(st); r.strb = 4'(strb); r.alu = 3'(alu); r.imm = 3'(imm);
        r.a = 2'(a); r.b = 2'(b); r.rs = 2'(rs); r.adr = 1'(adr); r.ill = 1'(ill);
        return r;
    endfunction

    function automatic logic [21:0] pk(vec_t r);
        return {r.st, r.strb, r.alu, r.imm, r.a, r.b, r.rs, r.adr, r.ill};
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply(vec_t r);
        vec_t e;
        op = r.op; funct3 = r.f3; funct7b5 = r.f7; zero = r.z; mem_ready = r.mr;
        sb.push_back(r);
        #2;
        e = sb.pop_front();
        chk($sformatf("vec%0d_state%0d", nvec, e.st), 32'(act), 32'(pk(e)));
        nvec++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(bit rel0);
        rst_n = 1'b0;
        rst0_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("reset_state", 32'(state), 0);
        chk("reset_strobes", {pc_write, ir_write, reg_write, mem_write, illegal}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rst0_n = rel0;
    endtask

    // four-row ALU instruction: FETCH, DECODE, EXECR/EXECI, ALUWB
    task automatic alu_seq(int o, int f3, int f7, int alu);
        int ex = (o == RT) ? 6 : 7;
        int b = (o == RT) ? 0 : 1;
        vecs.push_back(mk(o, f3, f7, 0, 1, 0, 4'b1100, 0, 0, 0, 2, 2, 0, 0));
        vecs.push_back(mk(o, f3, f7, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(o, f3, f7, 0, 1, ex, 0, alu, 0, 2, b, 0, 0, 0));
        vecs.push_back(mk(o, f3, f7, 0, 1, 8, 4'b0010, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic br_seq(int f3, int z, int pc);
        vecs.push_back(mk(BR, f3, 0, z, 1, 0, 4'b1100, 0, 2, 0, 2, 2, 0, 0));
        vecs.push_back(mk(BR, f3, 0, z, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(BR, f3, 0, z, 1, 9, pc << 3, 1, 2, 2, 0, 0, 0, 0));
    endtask

    initial begin
        // lw with FETCH and MEMREAD stalls: states 0,0,0,1,2,3,3,4
        vecs.push_back(mk(LW, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0));
        vecs.push_back(mk(LW, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0));
        vecs.push_back(mk(LW, 2, 0, 0, 1, 0, 4'b1100, 0, 0, 0, 2, 2, 0, 0));
        vecs.push_back(mk(LW, 2, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(LW, 2, 0, 0, 1, 2, 0, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(LW, 2, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(LW, 2, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(LW, 2, 0, 0, 1, 4, 4'b0010, 0, 0, 0, 0, 1, 0, 0));
        // sw with one wait cycle in MEMWRITE
        vecs.push_back(mk(SW, 2, 0, 0, 1, 0, 4'b1100, 0, 1, 0, 2, 2, 0, 0));
        vecs.push_back(mk(SW, 2, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(SW, 2, 0, 0, 0, 2, 0, 0, 1, 2, 1, 0, 0, 0));
        vecs.push_back(mk(SW, 2, 0, 0, 0, 5, 4'b0001, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(SW, 2, 0, 0, 1, 5, 4'b0001, 0, 1, 0, 0, 0, 1, 0));
        alu_seq(RT, 0, 1, 1);
        alu_seq(IT, 0, 1, 0);
        alu_seq(RT, 2, 0, 5);
        alu_seq(IT, 6, 0, 3);
        alu_seq(RT, 7, 1, 2);
        br_seq(0, 1, 1);
        br_seq(1, 1, 0);
        br_seq(1, 0, 1);
        br_seq(0, 0, 0);
        vecs.push_back(mk(JL, 0, 0, 0, 1, 0, 4'b1100, 0, 4, 0, 2, 2, 0, 0));
        vecs.push_back(mk(JL, 0, 0, 0, 1, 1, 0, 0, 4, 1, 1, 0, 0, 0));
        vecs.push_back(mk(JL, 0, 0, 0, 1, 10, 4'b1000, 0, 4, 1, 2, 0, 0, 0));
        vecs.push_back(mk(JL, 0, 0, 0, 1, 8, 4'b0010, 0, 4, 0, 0, 0, 0, 0));
        vecs.push_back(mk(LU, 0, 0, 0, 1, 0, 4'b1100, 0, 3, 0, 2, 2, 0, 0));
        vecs.push_back(mk(LU, 0, 0, 0, 1, 1, 0, 0, 3, 1, 1, 0, 0, 0));
        vecs.push_back(mk(LU, 0, 0, 0, 1, 11, 0, 0, 3, 3, 1, 0, 0, 0));
        vecs.push_back(mk(LU, 0, 0, 0, 1, 8, 4'b0010, 0, 3, 0, 0, 0, 0, 0));
        // branch with unsupported funct3 must trap and stay trapped
        vecs.push_back(mk(BR, 2, 0, 0, 1, 0, 4'b1100, 0, 2, 0, 2, 2, 0, 0));
        vecs.push_back(mk(BR, 2, 0, 0, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(BR, 2, 0, 0, 1, 15, 0, 0, 2, 0, 0, 0, 0, 1));
        vecs.push_back(mk(BR, 2, 0, 0, 1, 15, 0, 0, 2, 0, 0, 0, 0, 1));

        do_reset(1'b0);
        foreach (vecs[i]) apply(vecs[i]);

        // undefined opcode: halting instance parks, non-halting one refetches
        do_reset(1'b1);
        apply(mk(BAD, 0, 0, 0, 1, 0, 4'b1100, 0, 0, 0, 2, 2, 0, 0));
        apply(mk(BAD, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        chk("nohalt_error", {state0, illegal0}, {4'd15, 1'b1});
        apply(mk(BAD, 0, 0, 0, 1, 15, 0, 0, 0, 0, 0, 0, 0, 1));
        chk("nohalt_refetch", {state0, illegal0}, {4'd0, 1'b0});
        for (int i = 0; i < 10; i++) apply(mk(BAD, 0, 0, 0, 1, 15, 0, 0, 0, 0, 0, 0, 0, 1));

        // reset asserted in MEMWRITE while memory is stalled
        do_reset(1'b0);
        apply(mk(SW, 0, 0, 0, 1, 0, 4'b1100, 0, 1, 0, 2, 2, 0, 0));
        apply(mk(SW, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0));
        apply(mk(SW, 0, 0, 0, 0, 2, 0, 0, 1, 2, 1, 0, 0, 0));
        mem_ready = 1'b0;
        #2;
        chk("memwrite_before_reset", {state, mem_write}, {4'd5, 1'b1});
        rst_n = 1'b0;
        #1;
        chk("memwrite_async_reset", {state, pc_write, ir_write, reg_write, mem_write}, {4'd0, 4'b0000});
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(SW, 0, 0, 0, 1, 0, 4'b1100, 0, 1, 0, 2, 2, 0, 0));
        apply(mk(SW, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
